// File: rtl/shift_reg_serdes_pkg.sv
// rtl/shift_reg_serdes_pkg.sv - shared types for the shift-register serdes
package shift_reg_serdes_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serdes_state_t;

endpackage

// File: rtl/shift_reg_serdes_core.sv
// rtl/shift_reg_serdes_core.sv - WIDTH-bit load/shift/hold register with selectable direction
module shift_reg_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_shift,
    input  logic             i_sdi,
    output logic [WIDTH-1:0] o_shifted,
    output logic             o_out_bit
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;

    // Output end is the MSB when shifting left, the LSB when shifting right.
    generate
        if (MSB_FIRST) begin : g_left
            assign w_shifted = {r_shreg[WIDTH-2:0], i_sdi};
            assign o_out_bit = r_shreg[WIDTH-1];
        end else begin : g_right
            assign w_shifted = {i_sdi, r_shreg[WIDTH-1:1]};
            assign o_out_bit = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_d;
        end else if (i_shift) begin
            r_shreg <= w_shifted;
        end
    end

    assign o_shifted = w_shifted;

endmodule

// File: rtl/shift_reg_serdes.sv
// rtl/shift_reg_serdes.sv - full-duplex serializer/deserializer with valid/ready load
module shift_reg_serdes
    import shift_reg_serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    input  logic             sdi,
    output logic             sdo,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    serdes_state_t    r_state;
    serdes_state_t    w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;

    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign w_load  = (r_state == ST_IDLE) && load_valid;
    assign w_shift = (r_state == ST_SHIFT) && shift_en;
    assign w_last  = w_shift && (r_cnt == CNT_LAST);

    shift_reg_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_d       (d),
        .i_shift   (w_shift),
        .i_sdi     (sdi),
        .o_shifted (w_shifted),
        .o_out_bit (w_out_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (load_valid) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)     w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Counter and capture; q takes the post-shift value on the final shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_q       <= w_shifted;
                    r_q_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        sdo        = 1'b0;
        case (r_state)
            ST_IDLE:  load_ready = 1'b1;
            ST_SHIFT: begin
                busy = 1'b1;
                sdo  = w_out_bit;
            end
            default:  load_ready = 1'b0;
        endcase
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;

endmodule

// File: tb/tb_shift_reg_serdes.sv
// tb/tb_shift_reg_serdes.sv - scoreboard bench for shift_reg_serdes in both bit orders
module tb_shift_reg_serdes;

    logic       clk = 1'b0;
    logic       reset;
    logic       lv[2];
    logic       se[2];
    logic       sdi_drv[2];
    logic       lb[2];
    logic [7:0] din[2];
    logic       lr[2];
    logic       sdo[2];
    logic       busy[2];
    logic       qv[2];
    logic [7:0] q[2];
    logic       sdi_w[2];
    logic       prev_qv[2];

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sdi_w[0] = lb[0] ? sdo[0] : sdi_drv[0];
    assign sdi_w[1] = lb[1] ? sdo[1] : sdi_drv[1];

    shift_reg_serdes #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]), .d(din[0]),
        .shift_en(se[0]), .sdi(sdi_w[0]), .sdo(sdo[0]), .busy(busy[0]), .q(q[0]), .q_valid(qv[0])
    );

    shift_reg_serdes #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]), .d(din[1]),
        .shift_en(se[1]), .sdi(sdi_w[1]), .sdo(sdo[1]), .busy(busy[1]), .q(q[1]), .q_valid(qv[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the expected word whenever a DUT presents q_valid.
    always @(negedge clk) begin
        if (qv[0]) begin
            chk("qv_single_pulse_msb", {31'b0, prev_qv[0]}, 32'd0);
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_q_valid_msb actual=%0h expected=none", q[0]);
            end else begin
                chk("q_word_msb", {24'b0, q[0]}, {24'b0, exp_q0.pop_front()});
            end
        end
        prev_qv[0] <= qv[0];
    end

    always @(negedge clk) begin
        if (qv[1]) begin
            chk("qv_single_pulse_lsb", {31'b0, prev_qv[1]}, 32'd0);
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_q_valid_lsb actual=%0h expected=none", q[1]);
            end else begin
                chk("q_word_lsb", {24'b0, q[1]}, {24'b0, exp_q1.pop_front()});
            end
        end
        prev_qv[1] <= qv[1];
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // s=0 is the MSB-first instance, s=1 the LSB-first one; pat[n] is sdi on the n-th shift.
    task automatic frame(input int s, input logic [7:0] dv, input logic loop,
                         input logic [7:0] pat, input logic stall, input logic hold,
                         input logic [7:0] expq);
        int   n;
        int   c;
        logic en;
        logic exp_bit;
        n = 0;
        c = 0;
        lb[s]      = loop;
        din[s]     = dv;
        lv[s]      = 1'b1;
        se[s]      = 1'b1;
        sdi_drv[s] = 1'b0;
        if (s == 0) exp_q0.push_back(expq);
        else        exp_q1.push_back(expq);
        @(posedge clk);
        #1;
        if (hold) din[s] = ~dv;
        else      lv[s] = 1'b0;
        while (n < 8 && c < 64) begin
            en         = stall ? (c % 3 == 0) : 1'b1;
            se[s]      = en;
            sdi_drv[s] = pat[n];
            exp_bit    = (s == 0) ? dv[7-n] : dv[n];
            @(negedge clk);
            chk("busy_in_shift", {31'b0, busy[s]}, 32'd1);
            chk("load_ready_in_shift", {31'b0, lr[s]}, 32'd0);
            chk("sdo_bit", {31'b0, sdo[s]}, {31'b0, exp_bit});
            @(posedge clk);
            #1;
            if (en) n++;
            c++;
        end
        if (n < 8) chk("frame_timeout", n, 8);
        lv[s] = 1'b0;
        se[s] = 1'b0;
        @(negedge clk);
        chk("q_valid_latency", {31'b0, qv[s]}, 32'd1);
        chk("load_ready_on_done", {31'b0, lr[s]}, 32'd1);
        chk("busy_on_done", {31'b0, busy[s]}, 32'd0);
    endtask

    task automatic check_idle(input int s);
        chk("idle_busy", {31'b0, busy[s]}, 32'd0);
        chk("idle_load_ready", {31'b0, lr[s]}, 32'd1);
        chk("idle_sdo", {31'b0, sdo[s]}, 32'd0);
        chk("idle_q", {24'b0, q[s]}, 32'd0);
        chk("idle_q_valid", {31'b0, qv[s]}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0; se[i] = 1'b0; sdi_drv[i] = 1'b0; lb[i] = 1'b0; din[i] = 8'h00;
            prev_qv[i] = 1'b0;
        end
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check_idle(0);
        check_idle(1);
        idle(1);

        frame(0, 8'h12, 1'b1, 8'h00, 1'b0, 1'b0, 8'h12);
        idle(2);
        frame(1, 8'h12, 1'b1, 8'h00, 1'b0, 1'b0, 8'h12);
        idle(2);
        frame(0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF);
        idle(2);
        frame(0, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 8'h80);
        idle(2);
        frame(0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 8'hC0);
        idle(2);
        frame(1, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01);
        idle(2);
        frame(1, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 8'h03);
        idle(2);
        frame(0, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5);
        idle(2);
        frame(1, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C);
        idle(2);

        // load_valid held through SHIFT, then a second frame in the q_valid cycle.
        frame(0, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5A);
        frame(0, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC3);
        idle(2);

        // Reset after three shifts discards the frame.
        lb[0] = 1'b1; din[0] = 8'h96; lv[0] = 1'b1; se[0] = 1'b1;
        @(posedge clk);
        #1;
        lv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        se[0] = 1'b0;
        @(negedge clk);
        check_idle(0);
        idle(3);
        frame(0, 8'h69, 1'b1, 8'h00, 1'b0, 1'b0, 8'h69);
        idle(4);

        chk("scoreboard_empty_msb", exp_q0.size(), 32'd0);
        chk("scoreboard_empty_lsb", exp_q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
